apb_reg_slave: RTL and testbench



---
 rtl/apb_reg_slave_if.sv | 34 +++
 rtl/apb_reg_slave.sv | 122 ++++++++++++
 tb/tb_apb_reg_slave.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_reg_slave_if.sv
// APB completer-side bus bundle: the select/enable/address/data signals from the
// master and the ready/error/read-data response from the completer.
interface apb_reg_slave_if;
  logic        psel_i;
  logic        penable_i;
  logic [31:0] paddr_i;
  logic        pwrite_i;
  logic [31:0] pwdata_i;
  logic [31:0] prdata_o;
  logic        pready_o;
  logic        pslverr_o;

  modport slave (
    input  psel_i,
    input  penable_i,
    input  paddr_i,
    input  pwrite_i,
    input  pwdata_i,
    output prdata_o,
    output pready_o,
    output pslverr_o
  );

  modport master (
    output psel_i,
    output penable_i,
    output paddr_i,
    output pwrite_i,
    output pwdata_i,
    input  prdata_o,
    input  pready_o,
    input  pslverr_o
  );
endinterface

// File: rtl/apb_reg_slave.sv
// APB completer with a small bank of 32-bit registers, programmable wait states
// and an error response on decode misses. Exposes register 0 and a transfer counter.
module apb_reg_slave #(
  parameter logic [31:0] BASE_ADDR   = 32'hA000,
  parameter int          NUM_REGS    = 4,
  parameter int          WAIT_CYCLES = 1
) (
  input  logic                  pclk,
  input  logic                  preset,
  apb_reg_slave_if.slave        bus,
  output logic [31:0]           reg0_o,
  output logic [7:0]            txn_count_o
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DONE
  } state_t;

  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);
  localparam logic [31:0] SPAN      = 32'(4 * NUM_REGS);
  localparam bit          HAS_WAIT  = (WAIT_CYCLES > 0);

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  wait_cnt;
  logic [3:0]  wait_cnt_nxt;

  logic [31:0] regs [NUM_REGS];
  logic [31:0] offset;
  logic [3:0]  idx;
  logic        hit;
  logic        complete;
  logic [31:0] rd_sel;

  // Unsigned subtraction wraps addresses below the base to huge offsets, so the
  // explicit lower-bound compare and the span compare together bound the window.
  assign offset   = bus.paddr_i - BASE_ADDR;
  assign idx      = offset[5:2];
  assign hit      = (bus.paddr_i[1:0] == 2'b00) &&
                    (bus.paddr_i >= BASE_ADDR) &&
                    (offset < SPAN);
  assign complete = (state == ST_DONE) && bus.psel_i && bus.penable_i;

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state    <= ST_IDLE;
      wait_cnt <= 4'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      ST_IDLE: begin
        if (bus.psel_i) begin
          wait_cnt_nxt = WAIT_INIT;
          state_nxt    = HAS_WAIT ? ST_WAIT : ST_DONE;
        end
      end
      ST_WAIT: begin
        if (!bus.psel_i) begin
          state_nxt = ST_IDLE;
        end else if (wait_cnt == 4'd1) begin
          state_nxt = ST_DONE;
        end else begin
          wait_cnt_nxt = wait_cnt - 4'd1;
        end
      end
      ST_DONE: begin
        if (!bus.psel_i || bus.penable_i) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        regs[k] <= 32'd0;
      end
    end else begin
      for (int k = 0; k < NUM_REGS; k++) begin
        if (complete && bus.pwrite_i && hit && (idx == 4'(k))) begin
          regs[k] <= bus.pwdata_i;
        end
      end
    end
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      txn_count_o <= 8'd0;
    end else if (complete) begin
      txn_count_o <= txn_count_o + 8'd1;
    end
  end

  // Response outputs are zero outside the completion cycle, so the read mux can be
  // computed freely and gated at the end.
  always_comb begin
    rd_sel = 32'd0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (idx == 4'(k)) begin
        rd_sel = regs[k];
      end
    end
  end

  assign bus.pready_o  = complete;
  assign bus.pslverr_o = complete && !hit;
  assign bus.prdata_o  = (complete && hit && !bus.pwrite_i) ? rd_sel : 32'd0;
  assign reg0_o        = regs[0];

endmodule

// File: tb/tb_apb_reg_slave.sv
// Self-checking bench for apb_reg_slave: a one-wait-state instance carries most
// scenarios, a three-wait-state instance covers the longer access phase.
module tb_apb_reg_slave;

  logic pclk = 1'b0;
  logic preset;

  always #5 pclk = ~pclk;

  apb_reg_slave_if bus1 ();
  apb_reg_slave_if bus3 ();

  logic [31:0] reg0_1;
  logic [31:0] reg0_3;
  logic [7:0]  txn_1;
  logic [7:0]  txn_3;

  apb_reg_slave #(.BASE_ADDR(32'hA000), .NUM_REGS(4), .WAIT_CYCLES(1)) dut (
    .pclk(pclk), .preset(preset), .bus(bus1.slave), .reg0_o(reg0_1), .txn_count_o(txn_1)
  );

  apb_reg_slave #(.BASE_ADDR(32'hA000), .NUM_REGS(4), .WAIT_CYCLES(3)) dut3 (
    .pclk(pclk), .preset(preset), .bus(bus3.slave), .reg0_o(reg0_3), .txn_count_o(txn_3)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb [$];
  logic [31:0] model [4];
  int          model_cnt;
  int          checks = 0;
  int          errors = 0;

  function automatic bit model_hit(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a >= 32'hA000) && (a < 32'hA010);
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 4; k++) model[k] = 32'd0;
    model_cnt = 0;
    sb.delete();
  endtask

  // One transfer on the one-wait-state instance; hold keeps psel high so the next
  // call issues its setup phase immediately after completion.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                      input bit hold, output logic [31:0] rdata);
    exp_t e;
    int   cyc;
    bit   seen;
    rdata = 32'd0;
    @(negedge pclk);
    bus1.psel_i = 1'b1; bus1.penable_i = 1'b0;
    bus1.paddr_i = addr; bus1.pwrite_i = wr; bus1.pwdata_i = data;
    e.err   = !model_hit(addr);
    e.rdata = (!wr && !e.err) ? model[addr[3:2]] : 32'd0;
    sb.push_back(e);
    #1;
    checks++;
    if (bus1.pready_o !== 1'b0 || bus1.pslverr_o !== 1'b0 || bus1.prdata_o !== 32'd0) begin
      errors++;
      $display("[TB] FAIL setup_idle addr=%h: pready=%b pslverr=%b prdata=%h, required 0/0/0",
               addr, bus1.pready_o, bus1.pslverr_o, bus1.prdata_o);
    end
    @(negedge pclk);
    bus1.penable_i = 1'b1;
    cyc = 0; seen = 0;
    while (!seen && cyc < 20) begin
      #1;
      if (bus1.pready_o === 1'b1) seen = 1;
      else begin
        @(negedge pclk);
        cyc++;
      end
    end
    checks++;
    if (!seen || cyc != 1) begin
      errors++;
      $display("[TB] FAIL latency addr=%h: pready after %0d access cycles (seen=%0d), required 1",
               addr, cyc, seen);
    end
    e = sb.pop_front();
    if (seen) begin
      checks++;
      if (bus1.prdata_o !== e.rdata || bus1.pslverr_o !== e.err) begin
        errors++;
        $display("[TB] FAIL response addr=%h: prdata=%h pslverr=%b, required prdata=%h pslverr=%b",
                 addr, bus1.prdata_o, bus1.pslverr_o, e.rdata, e.err);
      end
      rdata = bus1.prdata_o;
      if (wr && !e.err) model[addr[3:2]] = data;
      model_cnt = (model_cnt + 1) % 256;
    end
    if (!hold) begin
      @(negedge pclk);
      bus1.psel_i = 1'b0; bus1.penable_i = 1'b0;
    end
  endtask

  task automatic test_reset();
    preset = 1'b1;
    bus1.psel_i = 0; bus1.penable_i = 0; bus1.paddr_i = 0; bus1.pwrite_i = 0; bus1.pwdata_i = 0;
    bus3.psel_i = 0; bus3.penable_i = 0; bus3.paddr_i = 0; bus3.pwrite_i = 0; bus3.pwdata_i = 0;
    model_clear();
    repeat (2) @(negedge pclk);
    #1;
    checks++;
    if ({bus1.pready_o, bus1.pslverr_o, bus1.prdata_o, reg0_1, txn_1} !== 66'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: pready=%b pslverr=%b prdata=%h reg0=%h txn=%0d, required all 0",
               bus1.pready_o, bus1.pslverr_o, bus1.prdata_o, reg0_1, txn_1);
    end
    checks++;
    if ({bus3.pready_o, bus3.pslverr_o, bus3.prdata_o, reg0_3, txn_3} !== 66'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs_w3: pready=%b pslverr=%b prdata=%h reg0=%h txn=%0d, required all 0",
               bus3.pready_o, bus3.pslverr_o, bus3.prdata_o, reg0_3, txn_3);
    end
    @(negedge pclk);
    preset = 1'b0;
  endtask

  task automatic test_write_read();
    logic [31:0] rd;
    xfer(1'b1, 32'hA004, 32'h1234_5678, 0, rd);
    xfer(1'b0, 32'hA004, 32'h0, 0, rd);
    checks++;
    if (rd !== 32'h1234_5678) begin
      errors++;
      $display("[TB] FAIL readback: got %h, required 12345678", rd);
    end
    #1;
    checks++;
    if (txn_1 !== 8'd2) begin
      errors++;
      $display("[TB] FAIL txn_after_wr_rd: got %0d, required 2", txn_1);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd;
    xfer(1'b1, 32'hA000, 32'hCAFE_0001, 0, rd);
    xfer(1'b1, 32'hA010, 32'hDEAD_BEEF, 0, rd);
    xfer(1'b1, 32'hA001, 32'hBAD0_0001, 0, rd);
    xfer(1'b0, 32'hA002, 32'h0, 0, rd);
    xfer(1'b0, 32'h9FFC, 32'h0, 0, rd);
    for (int k = 0; k < 4; k++) xfer(1'b0, 32'hA000 + 32'(4 * k), 32'h0, 0, rd);
    #1;
    checks++;
    if (txn_1 !== 8'(model_cnt) || reg0_1 !== model[0]) begin
      errors++;
      $display("[TB] FAIL after_errors: txn=%0d reg0=%h, required txn=%0d reg0=%h",
               txn_1, reg0_1, model_cnt, model[0]);
    end
  endtask

  task automatic test_abort();
    logic [31:0] rd;
    @(negedge pclk);
    bus1.psel_i = 1'b1; bus1.penable_i = 1'b0;
    bus1.paddr_i = 32'hA000; bus1.pwrite_i = 1'b1; bus1.pwdata_i = 32'hFFFF_0000;
    @(negedge pclk);
    bus1.psel_i = 1'b0; bus1.penable_i = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if (bus1.pready_o !== 1'b0) begin
        errors++;
        $display("[TB] FAIL abort_pready cycle %0d: got %b, required 0", c, bus1.pready_o);
      end
      @(negedge pclk);
    end
    bus1.penable_i = 1'b0;
    #1;
    checks++;
    if (txn_1 !== 8'(model_cnt) || reg0_1 !== model[0]) begin
      errors++;
      $display("[TB] FAIL abort_effect: txn=%0d reg0=%h, required txn=%0d reg0=%h",
               txn_1, reg0_1, model_cnt, model[0]);
    end
    xfer(1'b0, 32'hA000, 32'h0, 0, rd);
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    xfer(1'b1, 32'hA008, 32'h0BAD_F00D, 1, rd);
    xfer(1'b0, 32'hA008, 32'h0, 1, rd);
    xfer(1'b1, 32'hA00C, 32'h5555_AAAA, 1, rd);
    xfer(1'b0, 32'hA00C, 32'h0, 0, rd);
    #1;
    checks++;
    if (txn_1 !== 8'(model_cnt)) begin
      errors++;
      $display("[TB] FAIL b2b_count: got %0d, required %0d", txn_1, model_cnt);
    end
  endtask

  task automatic test_wait_states();
    exp_t e;
    @(negedge pclk);
    bus3.psel_i = 1'b1; bus3.penable_i = 1'b0;
    bus3.paddr_i = 32'hA000; bus3.pwrite_i = 1'b0; bus3.pwdata_i = 32'h0;
    e.rdata = 32'd0; e.err = 1'b0;
    sb.push_back(e);
    @(negedge pclk);
    bus3.penable_i = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      #1;
      checks++;
      if (bus3.pready_o !== (c == 4)) begin
        errors++;
        $display("[TB] FAIL wait3_pready T%0d: got %b, required %b", c, bus3.pready_o, (c == 4));
      end
      if (c == 4) begin
        e = sb.pop_front();
        checks++;
        if (bus3.prdata_o !== e.rdata || bus3.pslverr_o !== e.err) begin
          errors++;
          $display("[TB] FAIL wait3_response: prdata=%h pslverr=%b, required %h/%b",
                   bus3.prdata_o, bus3.pslverr_o, e.rdata, e.err);
        end
      end
      @(negedge pclk);
    end
    bus3.psel_i = 1'b0; bus3.penable_i = 1'b0;
    #1;
    checks++;
    if (txn_3 !== 8'd1 || bus3.pready_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL wait3_after: txn=%0d pready=%b, required 1/0", txn_3, bus3.pready_o);
    end
  endtask

  task automatic test_reset_midflight();
    logic [31:0] rd;
    xfer(1'b1, 32'hA000, 32'h0000_0055, 0, rd);
    @(negedge pclk);
    bus1.psel_i = 1'b1; bus1.penable_i = 1'b0;
    bus1.paddr_i = 32'hA000; bus1.pwrite_i = 1'b1; bus1.pwdata_i = 32'hAAAA_AAAA;
    @(negedge pclk);
    bus1.penable_i = 1'b1;
    @(negedge pclk);
    #1 preset = 1'b1;
    #1;
    checks++;
    if ({bus1.pready_o, bus1.pslverr_o, bus1.prdata_o, reg0_1, txn_1} !== 66'd0) begin
      errors++;
      $display("[TB] FAIL midflight_reset: pready=%b pslverr=%b prdata=%h reg0=%h txn=%0d, required all 0",
               bus1.pready_o, bus1.pslverr_o, bus1.prdata_o, reg0_1, txn_1);
    end
    model_clear();
    @(negedge pclk);
    preset = 1'b0;
    bus1.psel_i = 1'b0; bus1.penable_i = 1'b0;
    @(negedge pclk);
    #1;
    checks++;
    if (reg0_1 !== 32'd0 || txn_1 !== 8'd0) begin
      errors++;
      $display("[TB] FAIL no_partial_write: reg0=%h txn=%0d, required 0/0", reg0_1, txn_1);
    end
    xfer(1'b0, 32'hA000, 32'h0, 0, rd);
    xfer(1'b1, 32'hA004, 32'h0000_0077, 0, rd);
    xfer(1'b0, 32'hA004, 32'h0, 0, rd);
  endtask

  task automatic test_adder_master();
    logic [31:0] rd;
    @(negedge pclk);
    preset = 1'b1;
    model_clear();
    @(negedge pclk);
    preset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      xfer(1'b0, 32'hA000, 32'h0, 0, rd);
      xfer(1'b1, 32'hA000, model[0] + 32'd1, 0, rd);
      #1;
      checks++;
      if (reg0_1 !== 32'(i + 1)) begin
        errors++;
        $display("[TB] FAIL adder_reg0 step %0d: got %h, required %h", i, reg0_1, 32'(i + 1));
      end
    end
    checks++;
    if (txn_1 !== 8'd6) begin
      errors++;
      $display("[TB] FAIL adder_txn: got %0d, required 6", txn_1);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_errors();
    test_abort();
    test_back_to_back();
    test_wait_states();
    test_reset_midflight();
    test_adder_master();
    repeat (2) @(negedge pclk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
